bcd_bin_seq_ctrl: RTL and testbench

BCD_BIN_SEQ_CTRL -- requirements
Module: bcd_bin_seq_ctrl

---
 rtl/bcd_bin_pkg.sv | 20 ++
 rtl/bcd_rdd_step.sv | 28 ++
 rtl/bcd_bin_seq_ctrl.sv | 100 ++++++++++
 tb/tb_bcd_bin_seq_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_bin_pkg.sv
// rtl/bcd_bin_pkg.sv - shared sizes, state type and digit check for the BCD-to-binary converter
package bcd_bin_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int DIGIT_W    = 4;
  localparam int BIN_W      = 20;
  localparam int BCD_W      = NUM_DIGITS * DIGIT_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // A BCD digit is legal only in the range 0..9.
  function automatic logic digit_valid(input logic [DIGIT_W-1:0] digit);
    return (digit <= DIGIT_W'(9));
  endfunction

endpackage

// File: rtl/bcd_rdd_step.sv
// rtl/bcd_rdd_step.sv - one combinational reverse double-dabble iteration
module bcd_rdd_step
  import bcd_bin_pkg::*;
(
  input  logic [BCD_W-1:0] i_digits,
  input  logic [BIN_W-1:0] i_acc,
  output logic [BCD_W-1:0] o_digits,
  output logic [BIN_W-1:0] o_acc
);

  logic [BCD_W-1:0] w_shifted;

  // The units digit LSB falls out of the chain into the accumulator MSB.
  assign o_acc     = {i_digits[0], i_acc[BIN_W-1:1]};
  // Shifting the whole chain moves each digit LSB into the MSB of the digit below.
  assign w_shifted = {1'b0, i_digits[BCD_W-1:1]};

  // Halving a digit that received a borrowed 8 must yield +5, so digits >= 8 lose 3.
  always_comb begin
    o_digits = w_shifted;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_shifted[i*DIGIT_W +: DIGIT_W] >= DIGIT_W'(8)) begin
        o_digits[i*DIGIT_W +: DIGIT_W] = w_shifted[i*DIGIT_W +: DIGIT_W] - DIGIT_W'(3);
      end
    end
  end

endmodule

// File: rtl/bcd_bin_seq_ctrl.sv
// rtl/bcd_bin_seq_ctrl.sv - sequential six-digit BCD to 20-bit binary converter
module bcd_bin_seq_ctrl
  import bcd_bin_pkg::*;
#(
  parameter int ITER = 20
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [BCD_W-1:0] bcd_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [BIN_W-1:0] result_o
);

  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [BCD_W-1:0] r_digits;
  logic [BIN_W-1:0] r_acc;
  logic [BIN_W-1:0] r_result;
  logic             r_err;

  logic [BCD_W-1:0] w_digits_nxt;
  logic [BIN_W-1:0] w_acc_nxt;
  logic             w_all_valid;
  logic             w_last_iter;

  bcd_rdd_step u_step (
    .i_digits (r_digits),
    .i_acc    (r_acc),
    .o_digits (w_digits_nxt),
    .o_acc    (w_acc_nxt)
  );

  // A request is legal only if every incoming digit is 0..9.
  always_comb begin
    w_all_valid = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!digit_valid(bcd_i[i*DIGIT_W +: DIGIT_W])) begin
        w_all_valid = 1'b0;
      end
    end
  end

  assign w_last_iter = (r_cnt == CNT_W'(ITER - 1));

  // Control FSM plus datapath; result and error only move on entry to DONE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_digits <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) begin
            if (w_all_valid) begin
              r_digits <= bcd_i;
              r_acc    <= '0;
              r_cnt    <= '0;
              r_state  <= SHIFT;
            end else begin
              r_err    <= 1'b1;
              r_result <= '0;
              r_state  <= DONE;
            end
          end
        end
        SHIFT: begin
          r_digits <= w_digits_nxt;
          r_acc    <= w_acc_nxt;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last_iter) begin
            r_result <= w_acc_nxt;
            r_err    <= 1'b0;
            r_state  <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy_o   = (r_state != IDLE);
  assign done_o   = (r_state == DONE);
  assign err_o    = r_err;
  assign result_o = r_result;

endmodule

// File: tb/tb_bcd_bin_seq_ctrl.sv
// tb/tb_bcd_bin_seq_ctrl.sv - self-checking bench for bcd_bin_seq_ctrl
module tb_bcd_bin_seq_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [23:0] bcd_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [19:0] result_o;

  int n_checks = 0;
  int n_errors = 0;

  bcd_bin_seq_ctrl #(.ITER(20)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .bcd_i    (bcd_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .err_o    (err_o),
    .result_o (result_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [23:0] bcd;
    logic [19:0] res;
    logic        err;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Decimal value of the digits; any digit above 9 makes the request an error.
  task automatic ref_model(input logic [23:0] bcd, output logic [19:0] res, output logic e);
    int v;
    int d;
    v = 0;
    e = 1'b0;
    for (int i = 5; i >= 0; i--) begin
      d = int'(bcd[i*4 +: 4]);
      if (d > 9) e = 1'b1;
      v = v * 10 + d;
    end
    res = e ? 20'h0 : v[19:0];
  endtask

  // One start pulse, then watch until busy drops; optionally inject a stray start mid-flight.
  task automatic do_conv(input logic [23:0] bcd, input int inj_c, input logic [23:0] inj_bcd,
                         output int busy_cycles, output int done_pulses, output int done_at,
                         output int early_changes);
    logic [19:0] prev_res;
    logic        prev_err;
    prev_res = result_o;
    prev_err = err_o;
    start_i = 1'b1;
    bcd_i   = bcd;
    tick();
    start_i = 1'b0;
    bcd_i   = 24'($urandom);
    busy_cycles = 0;
    done_pulses = 0;
    done_at = -1;
    early_changes = 0;
    for (int c = 0; c < 60; c++) begin
      if (!busy_o) break;
      busy_cycles++;
      if (done_o) begin
        done_pulses++;
        if (done_at < 0) done_at = c;
      end else if (done_pulses == 0 && (result_o !== prev_res || err_o !== prev_err)) begin
        early_changes++;
      end
      start_i = (c == inj_c);
      bcd_i   = (c == inj_c) ? inj_bcd : 24'($urandom);
      tick();
      start_i = 1'b0;
    end
  endtask

  task automatic run_and_check(input string name, input logic [23:0] bcd,
                               input logic [19:0] exp_res, input logic exp_err,
                               input int inj_c, input logic [23:0] inj_bcd);
    int bc, dp, da, ec;
    do_conv(bcd, inj_c, inj_bcd, bc, dp, da, ec);
    chk({name, ".result"}, 32'(result_o), 32'(exp_res));
    chk({name, ".err"}, 32'(err_o), 32'(exp_err));
    chk({name, ".busy_cycles"}, bc, exp_err ? 1 : 21);
    chk({name, ".done_at"}, da, exp_err ? 0 : 20);
    chk({name, ".done_pulses"}, dp, 1);
    chk({name, ".early_change"}, ec, 0);
  endtask

  initial begin
    logic [19:0] m_res;
    logic        m_err;
    logic [23:0] rb;
    int          p1, p2, ndone;

    tbl[0] = '{24'h123456, 20'h1E240, 1'b0};
    tbl[1] = '{24'h999999, 20'hF423F, 1'b0};
    tbl[2] = '{24'h000000, 20'h00000, 1'b0};
    tbl[3] = '{24'h00000A, 20'h00000, 1'b1};
    tbl[4] = '{24'h000042, 20'h0002A, 1'b0};
    tbl[5] = '{24'h000100, 20'h00064, 1'b0};
    tbl[6] = '{24'hA00000, 20'h00000, 1'b1};
    tbl[7] = '{24'h090909, 20'd90909, 1'b0};

    rst_i = 1'b1;
    start_i = 1'b0;
    bcd_i = 24'h0;
    repeat (3) tick();
    chk("reset.busy", 32'(busy_o), 0);
    chk("reset.done", 32'(done_o), 0);
    chk("reset.err", 32'(err_o), 0);
    chk("reset.result", 32'(result_o), 0);
    rst_i = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      run_and_check($sformatf("tbl%0d", i), tbl[i].bcd, tbl[i].res, tbl[i].err, -1, 24'h0);
      repeat (2) tick();
      chk($sformatf("tbl%0d.hold", i), 32'(result_o), 32'(tbl[i].res));
    end

    for (int n = 0; n < 30; n++) begin
      for (int d = 0; d < 6; d++) begin
        rb[d*4 +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                  : 4'($urandom_range(0, 9));
      end
      ref_model(rb, m_res, m_err);
      run_and_check($sformatf("rand%0d", n), rb, m_res, m_err, -1, 24'h0);
      repeat ($urandom_range(0, 3)) tick();
    end

    run_and_check("ignored_start", 24'h000042, 20'h0002A, 1'b0, 5, 24'h000007);
    tick();
    chk("ignored_start.idle", 32'(busy_o), 0);

    start_i = 1'b1;
    bcd_i = 24'h000042;
    tick();
    p1 = -1; p2 = -1; ndone = 0;
    for (int c = 0; c < 45; c++) begin
      if (done_o) begin
        ndone++;
        if (p1 < 0) p1 = c; else if (p2 < 0) p2 = c;
      end
      tick();
    end
    start_i = 1'b0;
    chk("held_start.first_done", p1, 20);
    chk("held_start.second_done", p2, 42);
    chk("held_start.pulses", ndone, 2);
    for (int c = 0; c < 40 && busy_o; c++) tick();
    chk("held_start.drained", 32'(busy_o), 0);

    start_i = 1'b1;
    bcd_i = 24'h123456;
    tick();
    start_i = 1'b0;
    repeat (10) tick();
    chk("abort.in_shift", 32'(busy_o), 1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("abort.busy", 32'(busy_o), 0);
    chk("abort.done", 32'(done_o), 0);
    chk("abort.err", 32'(err_o), 0);
    chk("abort.result", 32'(result_o), 0);
    ndone = 0;
    for (int c = 0; c < 25; c++) begin
      if (done_o || busy_o) ndone++;
      tick();
    end
    chk("abort.quiet", ndone, 0);
    run_and_check("after_abort", 24'h000100, 20'h00064, 1'b0, -1, 24'h0);

    rst_i = 1'b1;
    start_i = 1'b1;
    bcd_i = 24'h000042;
    tick();
    rst_i = 1'b0;
    start_i = 1'b0;
    chk("rst_priority.busy", 32'(busy_o), 0);
    chk("rst_priority.result", 32'(result_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
